// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: stall bus layout, register address width and NOP encoding shared by the decode stage
package id_operand_stage_pkg;
  localparam int STALL_W = 6;
  localparam int STALL_IFID = 1;
  localparam int STALL_ID = 2;
  localparam int REG_AW = 5;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32-entry integer register file, two async reads, one write, r0 hardwired to zero
module regfile_2r1w
  import id_operand_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] ra0,
  input  logic [REG_AW-1:0] ra1,
  output logic [XLEN-1:0]   rd0,
  output logic [XLEN-1:0]   rd1
);
  logic [XLEN-1:0] mem [32];
  always_ff @(posedge clk)
    if (we && waddr != '0) mem[waddr] <= wdata;
  assign rd0 = ra0 == '0 ? '0 : mem[ra0];
  assign rd1 = ra1 == '0 ? '0 : mem[ra1];
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID register, SRAM instruction hold across stalls,
// priority bypass operand resolution and load-use stall request
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_BYP = 3,
  parameter int STALL_W = id_operand_stage_pkg::STALL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic                      if_valid,
  input  logic [XLEN-1:0]           if_pc,
  input  logic [31:0]               inst_rdata,
  input  logic                      use_rs,
  input  logic                      use_rt,
  input  logic [NUM_BYP-1:0]        byp_we,
  input  logic [NUM_BYP*REG_AW-1:0] byp_waddr,
  input  logic [NUM_BYP*XLEN-1:0]   byp_wdata,
  input  logic [NUM_BYP-1:0]        byp_pend,
  input  logic                      wb_we,
  input  logic [REG_AW-1:0]         wb_waddr,
  input  logic [XLEN-1:0]           wb_wdata,
  output logic                      id_valid,
  output logic [XLEN-1:0]           id_pc,
  output logic [31:0]               id_inst,
  output logic [XLEN-1:0]           rs_data,
  output logic [XLEN-1:0]           rt_data,
  output logic                      stallreq
);
  typedef struct packed {
    logic            hit;
    logic            pend;
    logic [XLEN-1:0] data;
  } opnd_t;
  logic              hold_vld;
  logic [31:0]       inst_hold;
  logic              id_hold;
  logic [REG_AW-1:0] rs_a, rt_a;
  logic [XLEN-1:0]   rf_rs, rf_rt;
  opnd_t             rs_r, rt_r;
  logic              unused_stall;
  assign unused_stall = ^stall;
  assign id_hold = !flush && stall[STALL_IFID] && stall[STALL_ID];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      hold_vld  <= 1'b0;
      inst_hold <= NOP;
    end else begin
      if (flush || (stall[STALL_IFID] && !stall[STALL_ID])) id_valid <= 1'b0;
      else if (!stall[STALL_IFID]) begin
        id_valid <= if_valid;
        id_pc    <= if_pc;
      end
      if (!id_hold) hold_vld <= 1'b0;
      else if (!hold_vld) begin
        hold_vld  <= 1'b1;
        inst_hold <= inst_rdata;
      end
    end
  assign id_inst = !id_valid ? NOP : (hold_vld ? inst_hold : inst_rdata);
  assign rs_a = id_inst[25:21];
  assign rt_a = id_inst[20:16];
  regfile_2r1w #(.XLEN(XLEN)) u_rf (
    .clk(clk), .we(wb_we), .waddr(wb_waddr), .wdata(wb_wdata),
    .ra0(rs_a), .ra1(rt_a), .rd0(rf_rs), .rd1(rf_rt)
  );
  // Sources scanned from lowest priority upward so the nearest stage overrides the rest.
  function automatic opnd_t resolve(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] rf);
    opnd_t r;
    r = '{hit: 1'b0, pend: 1'b0, data: (wb_we && wb_waddr == a) ? wb_wdata : rf};
    for (int k = NUM_BYP - 1; k >= 0; k--)
      if (byp_we[k] && byp_waddr[REG_AW*k +: REG_AW] == a)
        r = '{hit: 1'b1, pend: byp_pend[k], data: byp_wdata[XLEN*k +: XLEN]};
    return a == '0 ? '0 : r;
  endfunction
  always_comb begin
    rs_r = resolve(rs_a, rf_rs);
    rt_r = resolve(rt_a, rf_rt);
  end
  assign rs_data  = rs_r.data;
  assign rt_data  = rt_r.data;
  assign stallreq = id_valid && ((use_rs && rs_r.hit && rs_r.pend) || (use_rt && rt_r.hit && rt_r.pend));
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed and randomized checks of the decode operand stage against a behavioural model
module tb_id_operand_stage;
  localparam int XLEN = 32;
  localparam int NB = 3;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [5:0]        stall = '0;
  logic              flush = 1'b0;
  logic              if_valid = 1'b0;
  logic [XLEN-1:0]   if_pc = '0;
  logic [31:0]       inst_rdata = '0;
  logic              use_rs = 1'b0, use_rt = 1'b0;
  logic [NB-1:0]     byp_we = '0, byp_pend = '0;
  logic [NB*5-1:0]   byp_waddr = '0;
  logic [NB*XLEN-1:0] byp_wdata = '0;
  logic              wb_we = 1'b0;
  logic [4:0]        wb_waddr = '0;
  logic [XLEN-1:0]   wb_wdata = '0;
  logic              id_valid, stallreq;
  logic [XLEN-1:0]   id_pc, rs_data, rt_data;
  logic [31:0]       id_inst;
  int n_tests = 0;
  int n_fail = 0;
  logic [XLEN-1:0] mdl_rf [32];
  logic            exp_valid = 1'b0;
  logic [31:0]     exp_inst = '0;
  logic [XLEN-1:0] exp_pc = '0;

  always #5 clk = ~clk;

  id_operand_stage #(.XLEN(XLEN), .NUM_BYP(NB), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .inst_rdata(inst_rdata), .use_rs(use_rs), .use_rt(use_rt), .byp_we(byp_we),
    .byp_waddr(byp_waddr), .byp_wdata(byp_wdata), .byp_pend(byp_pend), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .rs_data(rs_data), .rt_data(rt_data), .stallreq(stallreq)
  );

  always @(posedge clk)
    if (wb_we && wb_waddr != 0) mdl_rf[wb_waddr] <= wb_wdata;

  function automatic logic [XLEN-1:0] mdl_op(input logic [4:0] a);
    if (a == 0) return '0;
    for (int k = 0; k < NB; k++)
      if (byp_we[k] && byp_waddr[5*k +: 5] == a) return byp_wdata[XLEN*k +: XLEN];
    if (wb_we && wb_waddr == a) return wb_wdata;
    return mdl_rf[a];
  endfunction

  function automatic logic mdl_pend(input logic [4:0] a, input logic used);
    if (a == 0 || !used) return 1'b0;
    for (int k = 0; k < NB; k++)
      if (byp_we[k] && byp_waddr[5*k +: 5] == a) return byp_pend[k];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ei;
    ei = exp_valid ? exp_inst : 32'h0;
    chk({tag, ".valid"}, 32'(id_valid), 32'(exp_valid));
    chk({tag, ".inst"}, id_inst, ei);
    chk({tag, ".rs"}, rs_data, mdl_op(ei[25:21]));
    chk({tag, ".rt"}, rt_data, mdl_op(ei[20:16]));
    chk({tag, ".stallreq"}, 32'(stallreq),
        32'(exp_valid & (mdl_pend(ei[25:21], use_rs) | mdl_pend(ei[20:16], use_rt))));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic load_inst(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    stall = 6'b000000;
    if_valid = 1'b1;
    if_pc = pc;
    tick();
    if_valid = 1'b0;
    stall = 6'b000110;
    inst_rdata = inst;
    tick();
    inst_rdata = $urandom;
    exp_valid = 1'b1;
    exp_inst = inst;
    exp_pc = pc;
  endtask

  task automatic clear_byp;
    byp_we = '0;
    byp_pend = '0;
    wb_we = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset.valid", 32'(id_valid), 32'h0);
    chk("reset.inst", id_inst, 32'h0);
    chk("reset.stallreq", 32'(stallreq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    wb_we = 1'b1;
    for (int r = 1; r < 32; r++) begin
      wb_waddr = 5'(r);
      wb_wdata = $urandom;
      tick();
    end
    wb_we = 1'b0;
    tick();
    // stall hold: SRAM data changes but ID keeps the fetched word
    stall = 6'b000000;
    if_valid = 1'b1;
    if_pc = 32'hBFC00000;
    tick();
    if_valid = 1'b0;
    stall = 6'b000110;
    inst_rdata = 32'h3C011234;
    exp_valid = 1'b1;
    exp_inst = 32'h3C011234;
    exp_pc = 32'hBFC00000;
    settle();
    chk("hold0.inst", id_inst, 32'h3C011234);
    chk("hold0.pc", id_pc, 32'hBFC00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_rdata = 32'hFFFFFFFF;
      settle();
      chk("hold.inst", id_inst, 32'h3C011234);
      chk("hold.pc", id_pc, 32'hBFC00000);
      check_all("hold");
    end
    // pending producer on rt=r1, then reset mid-stall clears everything at once
    byp_we = 3'b001;
    byp_waddr = {5'd0, 5'd0, 5'd1};
    byp_pend = 3'b001;
    use_rt = 1'b1;
    #1;
    check_all("pre_rst");
    chk("pre_rst.stall", 32'(stallreq), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst.valid", 32'(id_valid), 32'h0);
    chk("midrst.inst", id_inst, 32'h0);
    chk("midrst.stallreq", 32'(stallreq), 32'h0);
    exp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_byp();
    tick();
    settle();
    check_all("post_rst");
    // bubble
    load_inst(32'h100, 32'h12345678);
    settle();
    check_all("pre_bubble");
    tick();
    stall = 6'b000010;
    tick();
    exp_valid = 1'b0;
    settle();
    chk("bubble.valid", 32'(id_valid), 32'h0);
    chk("bubble.inst", id_inst, 32'h0);
    // flush beats a full stall
    load_inst(32'h200, 32'h0A0B0C0D);
    stall = 6'b000110;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_valid = 1'b0;
    settle();
    chk("flush.valid", 32'(id_valid), 32'h0);
    chk("flush.inst", id_inst, 32'h0);
    tick();
    settle();
    chk("flush_hold.inst", id_inst, 32'h0);
    // bypass priority on rs=r5, rt=r8
    load_inst(32'h300, (32'd5 << 21) | (32'd8 << 16));
    use_rs = 1'b1;
    byp_we = 3'b101;
    byp_waddr = {5'd5, 5'd9, 5'd5};
    byp_wdata = {32'h33, 32'h22, 32'h11};
    byp_pend = '0;
    wb_we = 1'b1;
    wb_waddr = 5'd5;
    wb_wdata = 32'h44;
    settle();
    chk("byp.k0", rs_data, 32'h11);
    check_all("byp.k0");
    tick();
    byp_we = 3'b100;
    settle();
    chk("byp.k2", rs_data, 32'h33);
    tick();
    byp_we = 3'b000;
    settle();
    chk("byp.wb", rs_data, 32'h44);
    tick();
    wb_we = 1'b0;
    settle();
    chk("byp.rf", rs_data, 32'h44);
    // load-use on rt=r8
    use_rs = 1'b0;
    use_rt = 1'b1;
    byp_we = 3'b001;
    byp_waddr = {5'd0, 5'd0, 5'd8};
    byp_pend = 3'b001;
    #1;
    chk("lu.stall", 32'(stallreq), 32'h1);
    use_rt = 1'b0;
    #1;
    chk("lu.unused", 32'(stallreq), 32'h0);
    use_rt = 1'b1;
    byp_we = 3'b011;
    byp_waddr = {5'd0, 5'd8, 5'd8};
    byp_wdata = {32'h33, 32'hBB, 32'hAA};
    byp_pend = 3'b010;
    #1;
    chk("lu.shadow", 32'(stallreq), 32'h0);
    chk("lu.shadow_rt", rt_data, 32'hAA);
    byp_pend = 3'b000;
    #1;
    check_all("lu.drop");
    // r0 never bypassed or written
    clear_byp();
    load_inst(32'h400, 32'h0);
    use_rs = 1'b1;
    use_rt = 1'b1;
    byp_we = 3'b111;
    byp_waddr = '0;
    byp_wdata = {3{32'hDEADBEEF}};
    byp_pend = 3'b111;
    wb_we = 1'b1;
    wb_waddr = 5'd0;
    wb_wdata = 32'hDEADBEEF;
    settle();
    chk("r0.rs", rs_data, 32'h0);
    chk("r0.stall", 32'(stallreq), 32'h0);
    tick();
    clear_byp();
    // randomized operand/hazard resolution
    for (int it = 0; it < 40; it++) begin
      load_inst($urandom, ($urandom & 32'hFC00FFFF) | (32'($urandom_range(0, 7)) << 21) | (32'($urandom_range(0, 7)) << 16));
      for (int s = 0; s < 4; s++) begin
        byp_we = NB'($urandom);
        byp_pend = NB'($urandom);
        for (int k = 0; k < NB; k++) begin
          byp_waddr[5*k +: 5] = 5'($urandom_range(0, 7));
          byp_wdata[XLEN*k +: XLEN] = $urandom;
        end
        wb_we = 1'($urandom);
        wb_waddr = 5'($urandom_range(0, 7));
        wb_wdata = $urandom;
        use_rs = 1'($urandom);
        use_rt = 1'($urandom);
        settle();
        check_all("rand");
        chk("rand.pc", id_pc, exp_pc);
        tick();
      end
      clear_byp();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
